// File: rtl/sort_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sort_pkg
//  Description : Shared sort-path constants and streamer state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package sort_pkg;

  localparam int ELEM_W = 8;
  localparam int N_ELEM = 8;
  localparam int SET_W  = ELEM_W * N_ELEM;
  localparam int IDX_W  = $clog2(N_ELEM);

  // Streamer FSM: waiting for a set, or walking through its elements
  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/sort_streamer_if.sv
`default_nettype none
// ============================================================================
//  Module      : sort_streamer_if
//  Description : Set-in / element-out handshake bundle of the sort streamer.
//                slave  = the streamer itself
//                master = its environment (sorter upstream, consumer down)
//  Revision    : 1.0  initial release
// ============================================================================
interface sort_streamer_if #(
  parameter int ELEM_W = 8,
  parameter int N_ELEM = 8
);

  localparam int SET_W = ELEM_W * N_ELEM;
  localparam int IDX_W = $clog2(N_ELEM);

  logic [SET_W-1:0]  setIn;
  logic              setValid;
  logic              setReady;
  logic [ELEM_W-1:0] elemOut;
  logic [IDX_W-1:0]  elemIdx;
  logic              elemValid;
  logic              elemReady;
  logic              elemLast;
  logic              orderErr;

  modport master (
    output setIn, setValid, elemReady,
    input  setReady, elemOut, elemIdx, elemValid, elemLast, orderErr
  );

  modport slave (
    input  setIn, setValid, elemReady,
    output setReady, elemOut, elemIdx, elemValid, elemLast, orderErr
  );

endinterface
`default_nettype wire

// File: rtl/sort_order_chk.sv
`default_nettype none
// ============================================================================
//  Module      : sort_order_chk
//  Description : Combinational ordering check of one set. Bit i of the mask
//                flags element i smaller than element i-1; bit 0 is always 0.
//  Revision    : 1.0  initial release
// ============================================================================
module sort_order_chk #(
  parameter int ELEM_W = 8,
  parameter int N_ELEM = 8
) (
  input  wire logic [ELEM_W*N_ELEM-1:0] setIn,
  output logic      [N_ELEM-1:0]        mask
);

  // Element 0 has no predecessor in its set
  assign mask[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 1; gi < N_ELEM; gi++) begin : g_cmp
      assign mask[gi] = setIn[gi*ELEM_W +: ELEM_W] < setIn[(gi-1)*ELEM_W +: ELEM_W];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/sort_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : sort_streamer
//  Description : Captures a sorted set and streams its elements one per
//                accepted handshake, back-to-back across sets.
//                Optional: define ORDER_CHECK_EN to flag out-of-order
//                elements on orderErr (otherwise orderErr is tied low).
//  Revision    : 1.0  initial release
// ============================================================================
module sort_streamer #(
  parameter int ELEM_W = sort_pkg::ELEM_W,
  parameter int N_ELEM = sort_pkg::N_ELEM
) (
  input wire logic       clk,
  input wire logic       rst,
  sort_streamer_if.slave bus
);

  import sort_pkg::*;

  localparam int SET_W = ELEM_W * N_ELEM;
  localparam int IDX_W = $clog2(N_ELEM);
  localparam logic [IDX_W-1:0] c_IDX_LAST = IDX_W'(N_ELEM - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [SET_W-1:0]  r_set;
  logic [ELEM_W-1:0] r_elem;
  logic [IDX_W-1:0]  r_idx;
  logic [IDX_W-1:0]  w_idx_nxt;
  logic              w_valid;
  logic              w_last;
  logic              w_set_ready;
  logic              w_accept;
  logic              w_advance;

  assign w_idx_nxt = r_idx + 1'b1;
  assign w_accept  = bus.setValid && w_set_ready;
  assign w_advance = w_valid && bus.elemReady && !w_last;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state and handshake outputs; a new set may load on the last element
  always_comb begin
    w_state_nxt = r_state;
    w_valid     = 1'b0;
    w_last      = 1'b0;
    w_set_ready = 1'b0;
    case (r_state)
      IDLE: begin
        w_set_ready = 1'b1;
        if (bus.setValid) w_state_nxt = STREAM;
      end
      STREAM: begin
        w_valid     = 1'b1;
        w_last      = (r_idx == c_IDX_LAST);
        w_set_ready = w_last && bus.elemReady;
        if (w_last && bus.elemReady && !bus.setValid) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Set capture, element index and registered element output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_set  <= '0;
      r_elem <= '0;
      r_idx  <= '0;
    end else if (w_accept) begin
      r_set  <= bus.setIn;
      r_elem <= bus.setIn[ELEM_W-1:0];
      r_idx  <= '0;
    end else if (w_advance) begin
      r_elem <= r_set[int'(w_idx_nxt)*ELEM_W +: ELEM_W];
      r_idx  <= w_idx_nxt;
    end
  end

  assign bus.setReady  = w_set_ready;
  assign bus.elemOut   = r_elem;
  assign bus.elemIdx   = r_idx;
  assign bus.elemValid = w_valid;
  assign bus.elemLast  = w_last;

`ifdef ORDER_CHECK_EN
  logic [N_ELEM-1:0] w_mask;
  logic [N_ELEM-1:0] r_mask;

  sort_order_chk #(
    .ELEM_W (ELEM_W),
    .N_ELEM (N_ELEM)
  ) u_order_chk (
    .setIn (bus.setIn),
    .mask  (w_mask)
  );

  // Violation mask is frozen with the set it describes
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_mask <= '0;
    else if (w_accept) r_mask <= w_mask;
  end

  assign bus.orderErr = r_mask[r_idx] && w_valid;
`else
  assign bus.orderErr = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sort_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sort_streamer
//  Description : Self-checking bench for sort_streamer against a queue-based
//                model of the element stream. Honours ORDER_CHECK_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sort_streamer;

  localparam int ELEM_W = 8;
  localparam int N_ELEM = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  sort_streamer_if #(.ELEM_W(ELEM_W), .N_ELEM(N_ELEM)) bus ();

  sort_streamer #(
    .ELEM_W (ELEM_W),
    .N_ELEM (N_ELEM)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [7:0] v;
    int         idx;
    bit         last;
    bit         err;
  } elem_t;

  // Elements still owed to the consumer, head = element currently presented
  elem_t q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic push_set(input logic [63:0] s);
    elem_t e;
    for (int i = 0; i < N_ELEM; i++) begin
      e.v    = s[8*i +: 8];
      e.idx  = i;
      e.last = (i == N_ELEM - 1);
`ifdef ORDER_CHECK_EN
      e.err  = (i > 0) && (s[8*i +: 8] < s[8*(i-1) +: 8]);
`else
      e.err  = 1'b0;
`endif
      q.push_back(e);
    end
  endtask

  function automatic bit exp_set_ready();
    return (q.size() == 0) || (q.size() == 1 && bus.elemReady);
  endfunction

  function automatic int head_idx();
    return (q.size() > 0) ? q[0].idx : -1;
  endfunction

  task automatic model_edge();
    bit sr;
    if (rst) begin
      q.delete();
      return;
    end
    sr = exp_set_ready();
    if (q.size() > 0 && bus.elemReady) q.delete(0);
    if (sr && bus.setValid) push_set(bus.setIn);
  endtask

  task automatic check_outputs();
    bit v;
    v = (q.size() > 0);
    chk("elemValid", bus.elemValid, v);
    chk("setReady", bus.setReady, exp_set_ready());
    if (v) begin
      chk("elemOut", bus.elemOut, q[0].v);
      chk("elemIdx", bus.elemIdx, q[0].idx);
      chk("elemLast", bus.elemLast, q[0].last);
      chk("orderErr", bus.orderErr, q[0].err);
    end else begin
      chk("elemLast_idle", bus.elemLast, 1'b0);
      chk("orderErr_idle", bus.orderErr, 1'b0);
    end
  endtask

  // Called at a falling edge: drive, check, advance one clock
  task automatic cycle(input bit sv, input logic [63:0] si, input bit er);
    bus.setValid  = sv;
    bus.setIn     = si;
    bus.elemReady = er;
    #1;
    check_outputs();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic run_to_idx(input int target, input string tag);
    int k;
    k = 0;
    while (head_idx() != target && k < 20) begin
      cycle(1'b0, rnd64(), 1'b1);
      k++;
    end
    chk(tag, head_idx(), target);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, rnd64(), 1'b1);
  endtask

  initial begin
    bus.setValid  = 1'b0;
    bus.setIn     = '0;
    bus.elemReady = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_elemValid", bus.elemValid, 1'b0);
    chk("rst_elemOut", bus.elemOut, 8'h00);
    chk("rst_elemIdx", bus.elemIdx, 3'd0);
    chk("rst_elemLast", bus.elemLast, 1'b0);
    chk("rst_orderErr", bus.orderErr, 1'b0);
    chk("rst_setReady", bus.setReady, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b0, '0, 1'b1);

    // Basic stream
    cycle(1'b1, 64'h0807060504030201, 1'b1);
    drain(9);

    // Backpressure at index 2
    cycle(1'b1, 64'h0807060504030201, 1'b1);
    run_to_idx(2, "bp_reach_idx2");
    for (int i = 0; i < 3; i++) cycle(1'b0, rnd64(), 1'b0);
    chk("bp_hold_elem", bus.elemOut, 8'h03);
    drain(8);

    // Back-to-back sets
    cycle(1'b1, 64'h0807060504030201, 1'b1);
    run_to_idx(7, "b2b_reach_last");
    cycle(1'b1, 64'hF0E0D0C0B0A09080, 1'b1);
    chk("b2b_first_elem", bus.elemOut, 8'h80);
    drain(9);

    // Descending set (order check)
    cycle(1'b1, 64'h0102030405060708, 1'b1);
    drain(9);

    // Reset mid-stream at index 4, asserted between edges
    cycle(1'b1, 64'h0807060504030201, 1'b1);
    run_to_idx(4, "mid_reach_idx4");
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_elemValid", bus.elemValid, 1'b0);
    chk("mid_rst_elemOut", bus.elemOut, 8'h00);
    chk("mid_rst_elemIdx", bus.elemIdx, 3'd0);
    q.delete();
    @(negedge clk);
    cycle(1'b0, rnd64(), 1'b1);
    rst = 1'b0;
    cycle(1'b1, 64'h1122334455667788, 1'b1);
    chk("mid_restart_idx0", bus.elemIdx, 3'd0);
    drain(9);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [63:0] s;
      s = rnd64();
      if ($urandom_range(0, 3) == 0) s = 64'hFFEEDDCCBBAA9988 - {56'd0, s[7:0]};
      cycle($urandom_range(0, 2) != 0, s, $urandom_range(0, 3) != 0);
    end
    drain(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
